// File: rtl/ooo_pkg.sv
// Shared out-of-order engine types: dispatch/issue/result records and the
// reservation-station entry layout.
package ooo_pkg;

    localparam int XLEN           = 32;
    localparam int ROB_ADDR_WIDTH = 5;
    localparam int OPCODE_WIDTH   = 8;
    localparam int RS_SIZE        = 4;

    typedef logic [XLEN-1:0]           data_t;
    typedef logic [ROB_ADDR_WIDTH-1:0] rob_tag_t;
    typedef logic [OPCODE_WIDTH-1:0]   opcode_t;

    typedef struct packed {
        logic     valid;
        data_t    pc;
        opcode_t  opcode;
        logic [4:0] rd_addr;
        logic     rd_write_en;
        data_t    v_rs1;
        rob_tag_t q_rs1;
        logic     q_rs1_valid;
        data_t    v_rs2;
        rob_tag_t q_rs2;
        logic     q_rs2_valid;
        rob_tag_t rob_tag;
    } ooo_dispatch_t;

    typedef struct packed {
        logic     valid;
        opcode_t  opcode;
        data_t    v_rs1;
        data_t    v_rs2;
        rob_tag_t rob_tag;
    } ooo_issue_t;

    typedef struct packed {
        logic     valid;
        rob_tag_t rob_tag;
        data_t    data;
        logic     exception_valid;
    } ooo_result_t;

    typedef struct packed {
        logic     busy;
        opcode_t  opcode;
        data_t    v_rs1;
        rob_tag_t q_rs1;
        logic     q_rs1_valid;
        data_t    v_rs2;
        rob_tag_t q_rs2;
        logic     q_rs2_valid;
        rob_tag_t rob_tag;
    } rs_entry_t;

    // An operand still waiting on a producer is satisfied by a matching broadcast.
    function automatic logic tag_hit(input logic cdb_valid, input rob_tag_t cdb_tag,
                                     input rob_tag_t tag, input logic waiting);
        return cdb_valid && waiting && (cdb_tag == tag);
    endfunction

endpackage

// File: rtl/ooo_rs_select.sv
// Picks one ready entry: lowest index by default, or smallest age rank when
// RS_AGE_SELECT_EN is defined.
module ooo_rs_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]            ready,
`ifdef RS_AGE_SELECT_EN
    input  logic [N-1:0][IDX_W-1:0] rank,
`endif
    output logic                    found,
    output logic [IDX_W-1:0]        idx
);

`ifdef RS_AGE_SELECT_EN
    logic [IDX_W-1:0] best_rank;

    always_comb begin
        found     = 1'b0;
        idx       = '0;
        best_rank = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!found || rank[i] < best_rank)) begin
                found     = 1'b1;
                idx       = IDX_W'(i);
                best_rank = rank[i];
            end
        end
    end
`else
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ready[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/ooo_reservation_station.sv
// Unified reservation station: allocate, CDB wakeup, select/issue, flush.
// Optional oldest-first selection via RS_AGE_SELECT_EN.
module ooo_reservation_station
    import ooo_pkg::*;
#(
    parameter int RS_SIZE   = ooo_pkg::RS_SIZE,
    parameter int CNT_WIDTH = $clog2(RS_SIZE + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  ooo_dispatch_t        dispatch_i,
    output logic                 dispatch_ready_o,
    input  ooo_result_t          cdb_i,
    output ooo_issue_t           issue_o,
    input  logic                 issue_ready_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t             entries [RS_SIZE];
    rs_entry_t             entries_next [RS_SIZE];
    rs_entry_t             new_entry;
    logic [CNT_WIDTH-1:0]  count, count_next;
    logic [RS_SIZE-1:0]    ready_vec;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  issue_fire;
    logic                  dispatch_fire;
`ifdef RS_AGE_SELECT_EN
    logic [RS_SIZE-1:0][IDX_W-1:0] rank, rank_next;
`endif

    // PC, destination and exception info are owned by the ROB, not stored here.
    logic unused_fields;
    assign unused_fields = ^{dispatch_i.pc, dispatch_i.rd_addr, dispatch_i.rd_write_en,
                             cdb_i.exception_valid};

    assign count_o          = count;
    assign dispatch_ready_o = (count != CNT_WIDTH'(RS_SIZE));
    assign dispatch_fire    = dispatch_i.valid && dispatch_ready_o;
    assign issue_fire       = issue_o.valid && issue_ready_i;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++)
            ready_vec[i] = entries[i].busy && !entries[i].q_rs1_valid && !entries[i].q_rs2_valid;
    end

    ooo_rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_select (
        .ready (ready_vec),
`ifdef RS_AGE_SELECT_EN
        .rank  (rank),
`endif
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        issue_o = '0;
        if (sel_found) begin
            issue_o.valid   = 1'b1;
            issue_o.opcode  = entries[sel_idx].opcode;
            issue_o.v_rs1   = entries[sel_idx].v_rs1;
            issue_o.v_rs2   = entries[sel_idx].v_rs2;
            issue_o.rob_tag = entries[sel_idx].rob_tag;
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!entries[i].busy) alloc_idx = IDX_W'(i);
    end

    // Operands produced in the dispatch cycle are captured straight off the CDB.
    always_comb begin
        new_entry             = '0;
        new_entry.busy        = 1'b1;
        new_entry.opcode      = dispatch_i.opcode;
        new_entry.rob_tag     = dispatch_i.rob_tag;
        new_entry.v_rs1       = dispatch_i.v_rs1;
        new_entry.q_rs1       = dispatch_i.q_rs1;
        new_entry.q_rs1_valid = dispatch_i.q_rs1_valid;
        new_entry.v_rs2       = dispatch_i.v_rs2;
        new_entry.q_rs2       = dispatch_i.q_rs2;
        new_entry.q_rs2_valid = dispatch_i.q_rs2_valid;
        if (tag_hit(cdb_i.valid, cdb_i.rob_tag, dispatch_i.q_rs1, dispatch_i.q_rs1_valid)) begin
            new_entry.v_rs1       = cdb_i.data;
            new_entry.q_rs1_valid = 1'b0;
        end
        if (tag_hit(cdb_i.valid, cdb_i.rob_tag, dispatch_i.q_rs2, dispatch_i.q_rs2_valid)) begin
            new_entry.v_rs2       = cdb_i.data;
            new_entry.q_rs2_valid = 1'b0;
        end
    end

    always_comb begin
        entries_next = entries;
        count_next   = count + CNT_WIDTH'(dispatch_fire) - CNT_WIDTH'(issue_fire);
`ifdef RS_AGE_SELECT_EN
        rank_next    = rank;
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            if (entries[i].busy) begin
                if (tag_hit(cdb_i.valid, cdb_i.rob_tag, entries[i].q_rs1, entries[i].q_rs1_valid)) begin
                    entries_next[i].v_rs1       = cdb_i.data;
                    entries_next[i].q_rs1_valid = 1'b0;
                end
                if (tag_hit(cdb_i.valid, cdb_i.rob_tag, entries[i].q_rs2, entries[i].q_rs2_valid)) begin
                    entries_next[i].v_rs2       = cdb_i.data;
                    entries_next[i].q_rs2_valid = 1'b0;
                end
            end
        end
        if (issue_fire) begin
            entries_next[sel_idx].busy = 1'b0;
`ifdef RS_AGE_SELECT_EN
            // Younger entries move up one rank so ranks stay dense from zero.
            for (int i = 0; i < RS_SIZE; i++)
                if (entries[i].busy && rank[i] > rank[sel_idx])
                    rank_next[i] = rank[i] - 1'b1;
`endif
        end
        if (dispatch_fire) begin
            entries_next[alloc_idx] = new_entry;
`ifdef RS_AGE_SELECT_EN
            rank_next[alloc_idx] = IDX_W'(count - CNT_WIDTH'(issue_fire));
`endif
        end
        if (flush_i) begin
            for (int i = 0; i < RS_SIZE; i++)
                entries_next[i].busy = 1'b0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the entry array is small flop storage, so it is fully zeroed on reset.
            for (int i = 0; i < RS_SIZE; i++)
                entries[i] <= '0;
            count <= '0;
`ifdef RS_AGE_SELECT_EN
            rank  <= '0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments only.
            entries <= entries_next;
            count   <= count_next;
`ifdef RS_AGE_SELECT_EN
            rank    <= rank_next;
`endif
        end
    end

endmodule

// File: doc/ooo_reservation_station.md
# ooo_reservation_station

Unified reservation station for the out-of-order engine. It sits between Decode/Rename and the functional units. It accepts `ooo_dispatch_t` entries, captures missing operands from the single-result common data bus (`ooo_result_t`), and issues operand-complete instructions as `ooo_issue_t`.

## Interface
Parameters:
- `RS_SIZE`, default `ooo_pkg::RS_SIZE`; number of entries (power of two, ≥2).
- `CNT_WIDTH`, default `$clog2(RS_SIZE+1)`; occupancy counter width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  discards all entries (mispredict/exception).
- `dispatch_i`  in  `ooo_dispatch_t`  incoming instruction; `.valid` is the request.
- `dispatch_ready_o`  out  1  entry free; transfer when `dispatch_i.valid && dispatch_ready_o`.
- `cdb_i`  in  `ooo_result_t`  result broadcast; `.valid` qualifies it.
- `issue_o`  out  `ooo_issue_t`  selected ready instruction; `.valid` is the request.
- `issue_ready_i`  in  1  FU accepts; transfer when `issue_o.valid && issue_ready_i`.
- `count_o`  out  `CNT_WIDTH`  occupied entries.

## Operation
- Each entry holds: busy, opcode, `v_rs1`/`q_rs1`/`q_rs1_valid`, `v_rs2`/`q_rs2`/`q_rs2_valid`, `rob_tag`. It is ready when busy and both `q_*_valid` are 0. PC, `rd_addr` and `rd_write_en` are not stored.
- **Allocate:** write to the lowest-index free entry.
  - If `cdb_i.valid` and `cdb_i.rob_tag` equals an incoming `q_rsX` with `q_rsX_valid=1` in the same cycle, store `cdb_i.data` and clear `q_rsX_valid`. Each operand is checked independently.
- **Wakeup:** for every busy entry and operand with `q_valid=1` and tag match, capture `cdb_i.data` and clear `q_valid`. `exception_valid` is ignored here; the ROB handles exceptions.
- **Select:** a combinational choice among ready entries, driven on `issue_o` (opcode, `v_rs1`, `v_rs2`, `rob_tag`). Default policy is lowest index. See Configuration.
- **Free:** on issue handshake, the selected entry's busy bit clears at the next edge.
- **Count:** `count_o` = +1 on dispatch, −1 on issue; both in one cycle leaves it unchanged.
- **Flush:** all busy bits cleared and `count_o` set to 0 at the next edge. It overrides same-cycle dispatch, issue and wakeup, and handshakes that cycle are dropped.
- **Reset:** same effect as flush. All stored fields are zeroed.

## Timing
- Reset values: `dispatch_ready_o=1`, `issue_o` all zero (`valid=0`), `count_o=0`.
- `dispatch_ready_o = (count_o != RS_SIZE)`, taken from registered state only. There is no path from `issue_ready_i`, so a full RS does not accept dispatch in the cycle an entry issues.
- Dispatch at edge N with both operands ready gives `issue_o.valid` from cycle N+1.
- CDB broadcast in cycle N (including capture at dispatch) makes the entry issuable in cycle N+1. There is no same-cycle CDB-to-issue bypass.
- `issue_o` may change while `issue_ready_i=0`: selection is re-evaluated every cycle, and a newly ready older or lower entry may replace it. No stability guarantee until the handshake.
- Combinational paths: `cdb_i` does not reach any output combinationally. `issue_o` depends on state only.

## Configuration
- Macro `RS_AGE_SELECT_EN`:
  - **Defined:** each entry carries an age rank. Dispatch assigns the rank `count` (after frees), and every issue decrements ranks above the issued one. Select picks the ready entry with the smallest rank (oldest first).
  - **Undefined:** no rank storage; select picks the lowest-index ready entry.
  - Interface and latency are identical in both builds.

## Structure
- `ooo_pkg` holds the shared types:
  - It already provides `ooo_dispatch_t`, `ooo_issue_t`, `ooo_result_t`, `ROB_ADDR_WIDTH`.
  - Add `rs_entry_t` (packed entry struct) there.
- One sub-module, `ooo_rs_select`: a parameterized ready-vector to one-hot/index picker.
  - Lowest-index priority encoder, or minimum-age search under `RS_AGE_SELECT_EN`.
  - Outputs `found` and `idx`.

## Test plan
- **Basic issue:** after reset, dispatch tag 3 with both operands ready (`v_rs1=5`, `v_rs2=7`), `issue_ready_i=1` → next cycle `issue_o.valid=1`, `rob_tag=3`, `v_rs1=5`, `v_rs2=7`; following cycle `count_o=0`.
- **Wakeup:** dispatch tag 2 with `q_rs1=4` waiting; 3 cycles later CDB broadcasts tag 4, data `0xDEADBEEF` → issue one cycle later with `v_rs1=0xDEADBEEF`. A non-matching CDB tag 5 causes no issue.
- **Dispatch/CDB collision:** dispatch waiting on tags 6 and 6 while CDB broadcasts tag 6, data `0x11` in the same cycle → both operands captured, issue next cycle with `v_rs1=v_rs2=0x11`.
- **Full:** with `issue_ready_i=0`, fill `RS_SIZE` entries → `dispatch_ready_o=0`, `count_o=RS_SIZE`. Raise `issue_ready_i` for one cycle → `dispatch_ready_o` returns to 1 the next cycle.
- **Flush:** with 3 entries held, assert `flush_i` together with a dispatch and an issue handshake → next cycle `count_o=0`, `issue_o.valid=0`, `dispatch_ready_o=1`.
- **Ordering (`RS_AGE_SELECT_EN`):** dispatch tags 1, 2, 3 all ready after issuing an earlier entry so tag 3 lands in a lower index → issue order is 1, 2, 3. Without the macro, the order follows index.
